// File: rtl/poly_sub_25_stream.sv
// poly_sub_25_stream: streaming (din1 - din2) mod Q on two W-bit lanes per 2W-bit word,
// two-stage valid/ready pipeline with frame tracking. Optional macro POLY_SUB_RANGE_CHK_EN adds range_err.
module poly_sub_25_stream #(
  parameter int unsigned Q       = 33292289,
  parameter int unsigned W       = 25,
  parameter int unsigned N_WORDS = 256
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_last,
  input  logic [2*W-1:0] din1,
  input  logic [2*W-1:0] din2,
  output logic [2*W-1:0] dout,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_last,
  output logic           out_rst,
  output logic           frame_err
`ifdef POLY_SUB_RANGE_CHK_EN
  ,
  output logic           range_err
`endif
);

  localparam int unsigned      CNT_W    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [W-1:0]     Q_W      = W'(Q);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_WORDS - 1);

  // Borrow-extended difference; bit W set means a < b.
  function automatic logic signed [W:0] lane_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

  function automatic logic [W-1:0] lane_wrap(input logic signed [W:0] d);
    return d[W] ? (d[W-1:0] + Q_W) : d[W-1:0];
  endfunction

  logic                 adv1, adv2, acc, last_beat;
  logic [CNT_W-1:0]     in_cnt;
  logic                 vld_p1, last_p1;
  logic signed [W:0]    d0_p1, d1_p1;
  logic [W-1:0]         r0_p1, r1_p1;
  logic                 vld_p2, last_p2;
  logic [2*W-1:0]       dout_p2;

  assign adv2      = !vld_p2 | out_ready;
  assign adv1      = !vld_p1 | adv2;
  assign in_ready  = adv1;
  assign acc       = in_valid & adv1;
  assign last_beat = (in_cnt == CNT_LAST);

  assign dout      = dout_p2;
  assign out_valid = vld_p2;
  assign out_last  = last_p2;

`ifdef POLY_SUB_RANGE_CHK_EN
  logic bad0_in, bad1_in, bad0_p1, bad1_p1;
  assign bad0_in = (din1[W-1:0] >= Q_W) | (din2[W-1:0] >= Q_W);
  assign bad1_in = (din1[2*W-1:W] >= Q_W) | (din2[2*W-1:W] >= Q_W);
`endif

  // Stage 0 -> 1: lane differences
  always_ff @(posedge clk) begin
    if (acc) begin
      d0_p1 <= lane_diff(din1[W-1:0], din2[W-1:0]);
      d1_p1 <= lane_diff(din1[2*W-1:W], din2[2*W-1:W]);
`ifdef POLY_SUB_RANGE_CHK_EN
      bad0_p1 <= bad0_in;
      bad1_p1 <= bad1_in;
`endif
    end
  end

  always_comb begin
    r0_p1 = lane_wrap(d0_p1);
    r1_p1 = lane_wrap(d1_p1);
`ifdef POLY_SUB_RANGE_CHK_EN
    if (bad0_p1) r0_p1 = '0;
    if (bad1_p1) r1_p1 = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_cnt    <= '0;
      frame_err <= 1'b0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      vld_p2    <= 1'b0;
      last_p2   <= 1'b0;
      dout_p2   <= '0;
      out_rst   <= 1'b0;
`ifdef POLY_SUB_RANGE_CHK_EN
      range_err <= 1'b0;
`endif
    end else begin
      if (acc) begin
        in_cnt <= last_beat ? '0 : in_cnt + 1'b1;
        if (in_last != last_beat) frame_err <= 1'b1;
`ifdef POLY_SUB_RANGE_CHK_EN
        if (bad0_in | bad1_in) range_err <= 1'b1;
`endif
      end
      if (adv1) begin
        vld_p1 <= in_valid;
        if (in_valid) last_p1 <= last_beat;
      end
      // Stage 1 -> 2: conditional modulus add
      if (adv2) begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          dout_p2 <= {r1_p1, r0_p1};
          last_p2 <= last_p1;
        end
      end
      out_rst <= vld_p2 & out_ready & last_p2;
    end
  end

endmodule
